// File: rtl/panda_pkg.sv
// ---------------------------------------------------------------------------
// panda_pkg
// Shared types and constants for the panda UART transmitter.
//   uart_state_e     : transmitter FSM state encoding
//   UART_*           : register indices (byte offset >> 2) in the 16-byte window
//   uart_status_word : packs the STATUS register image
// ---------------------------------------------------------------------------
package panda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Register indices, i.e. data_addr_i[3:2]
  localparam logic [1:0] UART_TXDATA = 2'd0;  // 0x0
  localparam logic [1:0] UART_STATUS = 2'd1;  // 0x4
  localparam logic [1:0] UART_CTRL   = 2'd2;  // 0x8
  localparam logic [1:0] UART_RSVD   = 2'd3;  // 0xC

  // STATUS layout: [0] full, [1] empty, [2] busy, [3] ovf, [15:8] count
  function automatic logic [31:0] uart_status_word(
    input logic       full,
    input logic       empty,
    input logic       busy,
    input logic       ovf,
    input logic [7:0] count
  );
    return {16'h0000, count, 4'h0, ovf, busy, empty, full};
  endfunction

endpackage

// File: rtl/panda_fifo.sv
// ---------------------------------------------------------------------------
// panda_fifo
// Generic synchronous FIFO. A push while full and a pop while empty are
// ignored; fullness is judged on the registered count, so a push on a full
// FIFO is dropped even if a pop happens on the same edge.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   push_i, wdata_i    write request and data
//   pop_i, rdata_o     read request and head-of-queue data (show-ahead)
//   full_o, empty_o    status flags
//   count_o            number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module panda_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/panda_uart_tx.sv
// ---------------------------------------------------------------------------
// panda_uart_tx
// Memory-mapped 8N1 UART transmitter with a TX FIFO, sitting on the core
// data port beside the data RAM.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   data_addr_i       byte address; selected when [31:4] matches BASE_ADDR
//   data_wdata_i      write data
//   data_we_i         byte strobes; only strobe 0 has an effect
//   data_rdata_o      registered read data (one cycle after the address)
//   tx_o              serial line, idle high, driven from a flop
// Registers (offset): 0x0 TXDATA (wo), 0x4 STATUS, 0x8 CTRL, 0xC reserved
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, waiting for en=1 and a queued byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high); chains straight into START if more is queued
// ---------------------------------------------------------------------------
module panda_uart_tx
  import panda_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_we_i,
  output logic [31:0] data_rdata_o,
  output logic        tx_o
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  // Register interface
  logic             sel;
  logic [1:0]       reg_idx;
  logic             wr_en;
  logic             push_req;
  logic             ovf_clr;
  logic             ctrl_wr;
  logic             en_q, en_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      rdata_q, rdata_d;

  // FIFO
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // Transmitter
  uart_state_e      state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             baud_end;
  logic             start_ok;

  logic             unused_bits;

  assign sel      = (data_addr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_idx  = data_addr_i[3:2];
  assign wr_en    = sel && data_we_i[0];
  assign push_req = wr_en && (reg_idx == UART_TXDATA);
  assign ovf_clr  = wr_en && (reg_idx == UART_STATUS) && data_wdata_i[3];
  assign ctrl_wr  = wr_en && (reg_idx == UART_CTRL);

  assign unused_bits = ^{data_addr_i[1:0], data_wdata_i[31:8], data_we_i[3:1]};

  panda_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_req),
    .wdata_i (data_wdata_i[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  always_comb begin
    en_d = en_q;
    if (ctrl_wr) begin
      en_d = data_wdata_i[0];
    end

    // A dropped push wins over a clear; both cannot target one register
    // in the same cycle anyway, since they decode different offsets.
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (push_req && fifo_full) begin
      ovf_d = 1'b1;
    end

    rdata_d = '0;
    if (sel) begin
      case (reg_idx)
        UART_STATUS: rdata_d = uart_status_word(fifo_full, fifo_empty,
                                                state_q != IDLE, ovf_q,
                                                8'(fifo_count));
        UART_CTRL:   rdata_d = {31'b0, en_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_rdata_o = rdata_q;

  // -------------------------------------------------------------------------
  // Transmit FSM
  // -------------------------------------------------------------------------
  assign baud_end = (baud_q == BAUD_LAST);
  assign start_ok = en_q && !fifo_empty;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (start_ok) begin
          state_d  = START;
          shift_d  = fifo_head;
          fifo_pop = 1'b1;
        end
      end

      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain the next frame without passing through IDLE so that
          // consecutive frames have no idle gap between them.
          if (start_ok) begin
            state_d  = START;
            shift_d  = fifo_head;
            fifo_pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Line level follows the state being entered so tx_o is a plain flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule
